// File: rtl/mano_pkg.sv
// mano_pkg: state encoding, opcodes and widths shared by the Mano sequencer.
package mano_pkg;

    localparam int T_W   = 3;
    localparam int OP_W  = 2;
    localparam int CNT_W = 8;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    localparam logic [OP_W-1:0] OP_NOP = 2'b00;
    localparam logic [OP_W-1:0] OP_LDA = 2'b01;
    localparam logic [OP_W-1:0] OP_MOV = 2'b10;
    localparam logic [OP_W-1:0] OP_HLT = 2'b11;

endpackage

// File: rtl/mano_step_latch.sv
// mano_step_latch: step rising-edge detect feeding a one-deep pending flag; clear wins over a coincident edge.
module mano_step_latch (
    input  logic clk,
    input  logic rst,
    input  logic i_step,
    input  logic i_clr,
    output logic o_pending
);

    logic r_step_q;
    logic r_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step_q <= 1'b0;
            r_pend   <= 1'b0;
        end else begin
            r_step_q <= i_step;
            r_pend   <= i_clr ? 1'b0 : (i_step & ~r_step_q) ? 1'b1 : r_pend;
        end
    end

    assign o_pending = r_pend;

endmodule

// File: rtl/mano_seq_ctrl.sv
// mano_seq_ctrl: T-state sequencer issuing tick-qualified register-transfer strobes.
// Optional single-step gating with MANO_SEQ_STEP_EN.
module mano_seq_ctrl
    import mano_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             run,
    input  logic             step,
    input  logic [OP_W-1:0]  ir_op,
    output logic             mar_ld_pc,
    output logic             mar_ld_mbr,
    output logic             pc_inc,
    output logic             mbr_ld_mem,
    output logic             ir_ld,
    output logic             a_ld_mbr,
    output logic             a_ld_r,
    output logic [T_W-1:0]   t_state,
    output logic             busy,
    output logic             halted,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired
);

    state_t             r_state;
    state_t             w_next;
    state_t             w_adv;
    state_t             w_after;
    logic               w_start;
    logic               w_valid;
    logic               w_in_t;
    logic [3:0]         w_tidx;
    logic [CNT_W-1:0]   r_retired;

`ifdef MANO_SEQ_STEP_EN
    logic w_pend;
    mano_step_latch u_step (
        .clk       (clk),
        .rst       (rst),
        .i_step    (step),
        .i_clr     ((w_next == S_T0) && (r_state != S_T0)),
        .o_pending (w_pend)
    );
    assign w_start = run & w_pend;
`else
    logic w_unused_step;
    assign w_unused_step = step;
    assign w_start = run;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (instr_done)
                r_retired <= r_retired + 1'b1;
        end
    end

    always_comb begin
        w_after = w_start ? S_T0 : S_IDLE;
        w_adv   = S_IDLE;
        case (r_state)
            S_IDLE: w_adv = w_after;
            S_T0:   w_adv = S_T1;
            S_T1:   w_adv = S_T2;
            S_T2:   w_adv = S_T3;
            S_T3:   w_adv = (ir_op == OP_HLT) ? S_HALT : (ir_op == OP_LDA) ? S_T4 : w_after;
            S_T4:   w_adv = S_T5;
            S_T5:   w_adv = S_T6;
            S_T6:   w_adv = S_T7;
            S_T7:   w_adv = w_after;
            S_HALT: w_adv = S_HALT;
            default: w_adv = S_IDLE;
        endcase
        w_valid = r_state <= S_HALT;
        w_next  = !w_valid ? S_IDLE : tick ? w_adv : r_state;
    end

    always_comb begin
        w_in_t     = (r_state >= S_T0) && (r_state <= S_T7);
        w_tidx     = r_state - S_T0;
        t_state    = w_in_t ? w_tidx[T_W-1:0] : '0;
        busy       = w_in_t;
        halted     = r_state == S_HALT;
        mar_ld_pc  = tick & ((r_state == S_T0) | ((r_state == S_T3) & (ir_op == OP_LDA)));
        mbr_ld_mem = tick & ((r_state == S_T1) | (r_state == S_T4) | (r_state == S_T6));
        pc_inc     = tick & ((r_state == S_T1) | (r_state == S_T4));
        ir_ld      = tick & (r_state == S_T2);
        mar_ld_mbr = tick & (r_state == S_T5);
        a_ld_mbr   = tick & (r_state == S_T7);
        a_ld_r     = tick & (r_state == S_T3) & (ir_op == OP_MOV);
        instr_done = tick & ((r_state == S_T7) |
                     ((r_state == S_T3) & ((ir_op == OP_NOP) | (ir_op == OP_MOV))));
        retired    = r_retired;
    end

endmodule

// File: tb/tb_mano_seq_ctrl.sv
// tb_mano_seq_ctrl: directed checks of the sequencer driving a small accumulator datapath model.
module tb_mano_seq_ctrl;

    logic       clk, rst, tick, run, step;
    logic [1:0] ir_op;
    logic       mar_ld_pc, mar_ld_mbr, pc_inc, mbr_ld_mem, ir_ld, a_ld_mbr, a_ld_r;
    logic [2:0] t_state;
    logic       busy, halted, instr_done;
    logic [7:0] retired;

    int tests = 0;
    int fails = 0;

    localparam logic [7:0] R_VAL = 8'h3C;
    logic [7:0] mem [256];
    logic [7:0] m_mar, m_mbr, m_pc, m_ir, m_a;
    logic [7:0] sv;

    mano_seq_ctrl dut (
        .clk(clk), .rst(rst), .tick(tick), .run(run), .step(step), .ir_op(ir_op),
        .mar_ld_pc(mar_ld_pc), .mar_ld_mbr(mar_ld_mbr), .pc_inc(pc_inc),
        .mbr_ld_mem(mbr_ld_mem), .ir_ld(ir_ld), .a_ld_mbr(a_ld_mbr), .a_ld_r(a_ld_r),
        .t_state(t_state), .busy(busy), .halted(halted), .instr_done(instr_done),
        .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign sv    = {mar_ld_pc, mar_ld_mbr, pc_inc, mbr_ld_mem, ir_ld, a_ld_mbr, a_ld_r, instr_done};
    assign ir_op = m_ir[1:0];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mar <= '0; m_mbr <= '0; m_pc <= '0; m_ir <= '0; m_a <= '0;
        end else begin
            if (mar_ld_pc)  m_mar <= m_pc;
            if (mar_ld_mbr) m_mar <= m_mbr;
            if (pc_inc)     m_pc  <= m_pc + 8'd1;
            if (mbr_ld_mem) m_mbr <= mem[m_mar];
            if (ir_ld)      m_ir  <= m_mbr;
            if (a_ld_mbr)   m_a   <= m_mbr;
            if (a_ld_r)     m_a   <= R_VAL;
        end
    end

    task automatic clear_mem;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1; tick = 1'b0; run = 1'b0; step = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; tick = 1'b0; run = 1'b0; step = 1'b0;
        clear_mem();
        #1;
        tests++; if (sv !== 8'h00) begin fails++; $display("FAIL reset_strobes got %h exp 00", sv); end
        tests++; if (t_state !== 3'd0) begin fails++; $display("FAIL reset_t_state got %0d exp 0", t_state); end
        tests++; if ({busy, halted} !== 2'b00) begin fails++; $display("FAIL reset_busy_halted got %b exp 00", {busy, halted}); end
        tests++; if (retired !== 8'd0) begin fails++; $display("FAIL reset_retired got %0d exp 0", retired); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_nop_mov;
        logic [7:0] e_sv [9];
        logic [2:0] e_t  [9];
        logic       e_b  [9];
        e_sv = '{8'h00, 8'h80, 8'h30, 8'h08, 8'h01, 8'h80, 8'h30, 8'h08, 8'h03};
        e_t  = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3};
        e_b  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        do_reset();
        clear_mem();
        mem[0] = 8'h00; mem[1] = 8'h02;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            tick = 1'b1; run = (i < 5);
            #1;
            tests++; if (sv !== e_sv[i]) begin fails++; $display("FAIL nop_mov_strobes[%0d] got %h exp %h", i, sv, e_sv[i]); end
            tests++; if (t_state !== e_t[i]) begin fails++; $display("FAIL nop_mov_t_state[%0d] got %0d exp %0d", i, t_state, e_t[i]); end
            tests++; if (busy !== e_b[i]) begin fails++; $display("FAIL nop_mov_busy[%0d] got %b exp %b", i, busy, e_b[i]); end
        end
        @(negedge clk);
        #1;
        tests++; if ({busy, sv} !== 9'h000) begin fails++; $display("FAIL nop_mov_idle got %h exp 000", {busy, sv}); end
        tests++; if (retired !== 8'd2) begin fails++; $display("FAIL nop_mov_retired got %0d exp 2", retired); end
        tests++; if (m_a !== R_VAL) begin fails++; $display("FAIL nop_mov_A got %h exp %h", m_a, R_VAL); end
    endtask

    task automatic test_lda;
        logic [7:0] e_sv [9];
        logic [2:0] e_t  [9];
        e_sv = '{8'h00, 8'h80, 8'h30, 8'h08, 8'h80, 8'h30, 8'h40, 8'h10, 8'h05};
        e_t  = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        do_reset();
        clear_mem();
        mem[0] = 8'h01; mem[1] = 8'h05; mem[5] = 8'hA7;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            tick = 1'b1; run = (i < 5);
            #1;
            tests++; if (sv !== e_sv[i]) begin fails++; $display("FAIL lda_strobes[%0d] got %h exp %h", i, sv, e_sv[i]); end
            tests++; if (t_state !== e_t[i]) begin fails++; $display("FAIL lda_t_state[%0d] got %0d exp %0d", i, t_state, e_t[i]); end
        end
        @(negedge clk);
        #1;
        tests++; if (m_a !== 8'hA7) begin fails++; $display("FAIL lda_A got %h exp a7", m_a); end
        tests++; if (m_pc !== 8'd2) begin fails++; $display("FAIL lda_PC got %0d exp 2", m_pc); end
        tests++; if (retired !== 8'd1) begin fails++; $display("FAIL lda_retired got %0d exp 1", retired); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL lda_idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_reset_mid;
        mem[2] = 8'h01; mem[3] = 8'h05;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tick = 1'b1; run = 1'b1;
        end
        @(negedge clk);
        #1;
        tests++; if ({t_state, sv} !== {3'd5, 8'h40}) begin fails++; $display("FAIL rst_mid_pre got %0d/%h exp 5/40", t_state, sv); end
        rst = 1'b1;
        #1;
        tests++; if (sv !== 8'h00) begin fails++; $display("FAIL rst_mid_strobes got %h exp 00", sv); end
        tests++; if (t_state !== 3'd0) begin fails++; $display("FAIL rst_mid_t_state got %0d exp 0", t_state); end
        tests++; if (retired !== 8'd0) begin fails++; $display("FAIL rst_mid_retired got %0d exp 0", retired); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
        @(negedge clk);
        rst = 1'b0; run = 1'b0; tick = 1'b0;
    endtask

    task automatic test_slow_tick;
        logic [7:0] e_sv [5];
        logic [2:0] e_t  [5];
        logic [7:0] exp_sv;
        int s;
        e_sv = '{8'h00, 8'h80, 8'h30, 8'h08, 8'h01};
        e_t  = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3};
        do_reset();
        clear_mem();
        for (int k = 0; k < 20; k++) begin
            s = k / 4;
            @(negedge clk);
            tick = (k % 4 == 3); run = (s < 2);
            #1;
            exp_sv = tick ? e_sv[s] : 8'h00;
            tests++; if (sv !== exp_sv) begin fails++; $display("FAIL slow_strobes[%0d] got %h exp %h", k, sv, exp_sv); end
            tests++; if (t_state !== e_t[s]) begin fails++; $display("FAIL slow_t_state[%0d] got %0d exp %0d", k, t_state, e_t[s]); end
        end
        @(negedge clk);
        tick = 1'b0;
        #1;
        tests++; if (retired !== 8'd1) begin fails++; $display("FAIL slow_retired got %0d exp 1", retired); end
    endtask

    task automatic test_halt;
        logic [7:0] e_sv [9];
        e_sv = '{8'h00, 8'h80, 8'h30, 8'h08, 8'h01, 8'h80, 8'h30, 8'h08, 8'h00};
        do_reset();
        clear_mem();
        mem[1] = 8'h03;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            tick = 1'b1; run = 1'b1;
            #1;
            tests++; if (sv !== e_sv[i]) begin fails++; $display("FAIL halt_strobes[%0d] got %h exp %h", i, sv, e_sv[i]); end
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            run = i[0];
            #1;
            tests++; if ({halted, busy, t_state, sv} !== {2'b10, 3'd0, 8'h00}) begin
                fails++; $display("FAIL halt_hold[%0d] got h%b b%b t%0d s%h exp h1 b0 t0 s00", i, halted, busy, t_state, sv);
            end
            tests++; if (retired !== 8'd1) begin fails++; $display("FAIL halt_retired[%0d] got %0d exp 1", i, retired); end
        end
        do_reset();
        #1;
        tests++; if (halted !== 1'b0) begin fails++; $display("FAIL halt_release got %b exp 0", halted); end
    endtask

`ifdef MANO_SEQ_STEP_EN
    task automatic test_step;
        int dones = 0;
        do_reset();
        clear_mem();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            tick = 1'b1; run = 1'b1; step = (c == 3) || (c == 5) || (c == 7);
            #1;
            if (instr_done) dones++;
            if (c == 2) begin
                tests++; if (busy !== 1'b0) begin fails++; $display("FAIL step_wait_busy got %b exp 0", busy); end
            end
        end
        step = 1'b0;
        tests++; if (dones != 2) begin fails++; $display("FAIL step_done_count got %0d exp 2", dones); end
        tests++; if (retired !== 8'd2) begin fails++; $display("FAIL step_retired got %0d exp 2", retired); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL step_final_busy got %b exp 0", busy); end
    endtask
`endif

    initial begin
        test_reset();
        test_nop_mov();
        test_lda();
        test_reset_mid();
        test_slow_tick();
        test_halt();
`ifdef MANO_SEQ_STEP_EN
        test_step();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
